// File: rtl/counter_pkg.sv
// Shared constants for the parameterised synchronous counter.
//   MODE_WRAP : the count wraps to the opposite limit when it passes a limit
//   MODE_SAT  : the count holds at the limit it has reached
package counter_pkg;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // Legal range of the counter width parameter.
    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/t_ff_ar.sv
// T flip-flop with asynchronous active-low reset (reset value 0).
//   clk   : clock, state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   t     : toggle enable
//   q     : registered state
module t_ff_ar (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    // Toggle the stored bit whenever t is high at the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/param_sync_counter.sv
// Parameterised up/down counter built from T flip-flops.
// Parameters:
//   WIDTH     : counter width in bits (2..32)
//   MAX_COUNT : highest count value (1..2**WIDTH-1)
//   SATURATE  : MODE_WRAP wraps at the limits, MODE_SAT holds at the limits
// Ports:
//   CLK      : clock
//   RST_N    : asynchronous active-low reset
//   EN       : count enable
//   UP       : direction, 1 = increment, 0 = decrement
//   CLR      : synchronous clear (highest priority)
//   LOAD     : synchronous load of LOAD_VAL, clamped to MAX_COUNT
//   LOAD_VAL : load value
//   Q        : registered count
//   TC       : combinational terminal-count flag
//   OVF      : registered one-cycle pulse after an edge taken at a limit
module param_sync_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
    parameter bit               SATURATE  = MODE_WRAP
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             EN,
    input  logic             UP,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] load_sat;
    logic             at_max;
    logic             at_zero;
    logic             ovf_next;

    assign at_max   = (cnt == MAX_COUNT);
    assign at_zero  = (cnt == '0);
    assign load_sat = (LOAD_VAL > MAX_COUNT) ? MAX_COUNT : LOAD_VAL;

    // Direction-dependent carry chain: bit i toggles when every lower bit is
    // 1 (counting up) or 0 (counting down).
    always_comb begin
        logic run;
        run   = 1'b1;
        carry = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            carry[i] = run;
            run      = run & (UP ? cnt[i] : ~cnt[i]);
        end
    end

    // Toggle selection: special edges force toggle = cnt ^ next_value.
    always_comb begin
        toggle   = '0;
        ovf_next = 1'b0;
        if (CLR) begin
            toggle = cnt;
        end else if (LOAD) begin
            toggle = cnt ^ load_sat;
        end else if (EN) begin
            toggle = carry;
            if (UP && at_max) begin
                ovf_next = 1'b1;
                toggle   = (SATURATE == MODE_SAT) ? '0 : cnt;
            end else if (!UP && at_zero) begin
                ovf_next = 1'b1;
                toggle   = (SATURATE == MODE_SAT) ? '0 : (cnt ^ MAX_COUNT);
            end
        end
    end

    // One T flip-flop per count bit.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        t_ff_ar u_bit (
            .clk   (CLK),
            .rst_n (RST_N),
            .t     (toggle[i]),
            .q     (cnt[i])
        );
    end

    // Limit-hit pulse register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OVF <= 1'b0;
        end else begin
            OVF <= ovf_next;
        end
    end

    assign Q  = cnt;
    assign TC = EN & (UP ? at_max : at_zero);

endmodule
